// File: rtl/trng_com_pkg.sv
// Shared definitions for the TRNG serial link: frame shape, default bit timing
// and the receiver FSM state encoding.
package trng_com_pkg;

  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;
  localparam int DEF_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead receive buffer; a push into a full buffer is dropped unless a pop
// frees the slot in the same cycle.
module rx_fifo #(
  parameter int DEPTH_WIDTH = 2,
  parameter int WIDTH       = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_push_dat,
  input  logic                 i_pop,
  output logic [WIDTH-1:0]     o_head,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [DEPTH_WIDTH:0] o_count,
  output logic                 o_push_ok,
  output logic                 o_overrun
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_CNT = (DEPTH_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   count;
  logic                   pop_ok;

  assign o_full    = (count == FULL_CNT);
  assign o_empty   = (count == '0);
  assign pop_ok    = i_pop && !o_empty;
  assign o_push_ok = i_push && (!o_full || pop_ok);
  assign o_head    = mem[rd_ptr];
  assign o_count   = count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      o_overrun <= i_push && !o_push_ok;
      if (o_push_ok) begin
        mem[wr_ptr] <= i_push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({o_push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trng_com_rx.sv
// 8N1 serial receiver for the TRNG link: synchronizer, bit-timing FSM,
// show-ahead byte buffer and RTS flow control.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | line idle high, waiting for a start edge
// ST_START     | half a bit into the start bit, confirm it is still low
// ST_DATA      | sample 8 data bits LSB first, one per bit period
// ST_STOP      | sample the stop bit; push the byte or flag a framing error
// ST_WAIT_IDLE | after a framing error, wait for the line to return high
module trng_com_rx
  import trng_com_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DEPTH_WIDTH  = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_serial_data,
  output logic       o_serial_rts_n,
  output logic [7:0] o_dat,
  output logic       o_valid,
  input  logic       i_read,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic [3:0] o_dat_cnt
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [15:0] BIT_TC  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [DEPTH_WIDTH:0] RTS_LVL = (DEPTH_WIDTH + 1)'(DEPTH - 1);

  logic                 sync_q1;
  logic                 rx_s;
  rx_state_e            state;
  logic [15:0]          tmr;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DEPTH_WIDTH:0] fifo_count;
  logic                 push_ok;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_q1 <= i_serial_data;
      rx_s    <= sync_q1;
    end
  end

  // tmr is a down-counter; every sample point is its terminal count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      push        <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      push        <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            tmr     <= HALF_TC;
            bit_idx <= '0;
          end
        end
        ST_START: begin
          if (tmr == '0) begin
            tmr   <= BIT_TC;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_DATA: begin
          if (tmr == '0) begin
            tmr   <= BIT_TC;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == LAST_BIT) state <= ST_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_STOP: begin
          if (tmr == '0) begin
            if (rx_s) begin
              push  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= ST_WAIT_IDLE;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rx_fifo #(
    .DEPTH_WIDTH(DEPTH_WIDTH),
    .WIDTH      (8)
  ) u_rx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push),
    .i_push_dat(shreg),
    .i_pop     (i_read),
    .o_head    (o_dat),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (fifo_count),
    .o_push_ok (push_ok),
    .o_overrun (o_overrun)
  );

  assign o_valid = !fifo_empty;

  // Occupancy can never exceed DEPTH, so ">= DEPTH-1" is "full or one short".
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dat_cnt      <= '0;
      o_serial_rts_n <= 1'b1;
    end else begin
      if (push_ok) o_dat_cnt <= o_dat_cnt + 1'b1;
      o_serial_rts_n <= fifo_full || (fifo_count == RTS_LVL);
    end
  end

endmodule
